// File: rtl/atm_pkg.sv
// Shared state encodings and default parameter values for the ATM transaction controller.
package atm_pkg;

  localparam int unsigned DefPinW        = 16;
  localparam int unsigned DefAmtW        = 16;
  localparam int unsigned DefBalW        = 24;
  localparam int unsigned DefMaxTries    = 3;
  localparam int unsigned DefLockCycles  = 120;
  localparam int unsigned DefIdleTimeout = 1000;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPin      = 3'd1,
    StMenu     = 3'd2,
    StShowBal  = 3'd3,
    StAmount   = 3'd4,
    StDispense = 3'd5
  } atm_state_e;

endpackage

// File: rtl/atm_lockout.sv
// Wrong-PIN attempt counter and lockout timer.
module atm_lockout import atm_pkg::*; #(
  parameter int unsigned MAX_TRIES   = DefMaxTries,
  parameter int unsigned LOCK_CYCLES = DefLockCycles
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             fail,
  input  logic                             success,
  output logic                             locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CntW   = $clog2(LOCK_CYCLES + 1);

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              locked_d;
  logic [TriesW-1:0] tries_d;

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked;
    tries_d  = tries_left;
    if (locked) begin
      // Unlock on the LOCK_CYCLES-th edge after the lockout began.
      if (cnt_q == CntW'(LOCK_CYCLES - 1)) begin
        locked_d = 1'b0;
        tries_d  = TriesW'(MAX_TRIES);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (success) begin
      tries_d = TriesW'(MAX_TRIES);
    end else if (fail) begin
      if (tries_left <= TriesW'(1)) begin
        tries_d  = '0;
        locked_d = 1'b1;
        cnt_d    = '0;
      end else begin
        tries_d = tries_left - TriesW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      locked     <= 1'b0;
      tries_left <= TriesW'(MAX_TRIES);
    end else begin
      cnt_q      <= cnt_d;
      locked     <= locked_d;
      tries_left <= tries_d;
    end
  end

endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM session controller: card insert, PIN check, menu, balance display and cash withdrawal.
module atm_txn_ctrl import atm_pkg::*; #(
  parameter int unsigned PIN_W        = DefPinW,
  parameter int unsigned AMT_W        = DefAmtW,
  parameter int unsigned BAL_W        = DefBalW,
  parameter int unsigned MAX_TRIES    = DefMaxTries,
  parameter int unsigned LOCK_CYCLES  = DefLockCycles,
  parameter int unsigned IDLE_TIMEOUT = DefIdleTimeout
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           card_in,
  input  logic                           pin_valid,
  input  logic [PIN_W-1:0]               pin_in,
  input  logic [PIN_W-1:0]               stored_pin,
  input  logic [BAL_W-1:0]               bal_in,
  input  logic                           sel_exit,
  input  logic                           sel_balance,
  input  logic                           sel_withdraw,
  input  logic                           amt_valid,
  input  logic [AMT_W-1:0]               amt_in,
  input  logic                           cash_done,
  output logic [2:0]                     state,
  output logic                           auth_ok,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           pin_err,
  output logic                           insuff,
  output logic                           timeout,
  output logic                           dispense_req,
  output logic [AMT_W-1:0]               dispense_amt,
  output logic [BAL_W-1:0]               balance_out,
  output logic                           bal_valid
);

  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);

  atm_state_e        state_q, state_d;
  logic [BAL_W-1:0]  bal_q, bal_d;
  logic [AMT_W-1:0]  damt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              pin_err_d, insuff_d, timeout_d;
  logic              fail, success, activity, active_st;
  logic [BAL_W-1:0]  amt_ext, damt_ext;

  assign amt_ext  = BAL_W'(amt_in);
  assign damt_ext = BAL_W'(dispense_amt);
  assign activity = pin_valid | sel_exit | sel_balance | sel_withdraw | amt_valid;
  assign active_st = state_q inside {StPin, StMenu, StShowBal, StAmount};

  atm_lockout #(
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lockout (
    .clk       (clk),
    .reset_n   (reset_n),
    .fail      (fail),
    .success   (success),
    .locked    (locked),
    .tries_left(tries_left)
  );

  always_comb begin
    state_d   = state_q;
    bal_d     = bal_q;
    damt_d    = dispense_amt;
    pin_err_d = 1'b0;
    insuff_d  = 1'b0;
    timeout_d = 1'b0;
    fail      = 1'b0;
    success   = 1'b0;
    idle_d    = '0;
    case (state_q)
      StIdle: begin
        if (card_in && !locked) begin
          state_d = StPin;
          bal_d   = bal_in;
        end
      end
      StPin: begin
        if (pin_valid) begin
          if (pin_in == stored_pin) begin
            state_d = StMenu;
            success = 1'b1;
          end else begin
            fail      = 1'b1;
            pin_err_d = 1'b1;
            if (tries_left <= TriesW'(1)) state_d = StIdle;
          end
        end
      end
      StMenu: begin
        if (sel_exit)          state_d = StIdle;
        else if (sel_balance)  state_d = StShowBal;
        else if (sel_withdraw) state_d = StAmount;
      end
      StShowBal: begin
        if (sel_exit)          state_d = StIdle;
        else if (sel_withdraw) state_d = StAmount;
      end
      StAmount: begin
        if (sel_exit) begin
          state_d = StIdle;
        end else if (amt_valid && (amt_in != '0)) begin
          if (amt_ext > bal_q) begin
            insuff_d = 1'b1;
            state_d  = StMenu;
          end else begin
            damt_d  = amt_in;
            state_d = StDispense;
          end
        end
      end
      StDispense: begin
        if (cash_done) begin
          bal_d   = (bal_q >= damt_ext) ? bal_q - damt_ext : '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inactivity watchdog; any strobe or state change restarts the count.
    if (active_st && !activity && (state_d == state_q)) begin
      if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
        state_d   = StIdle;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bal_q        <= '0;
      idle_q       <= '0;
      pin_err      <= 1'b0;
      insuff       <= 1'b0;
      timeout      <= 1'b0;
      auth_ok      <= 1'b0;
      bal_valid    <= 1'b0;
      balance_out  <= '0;
      dispense_req <= 1'b0;
      dispense_amt <= '0;
    end else begin
      state_q      <= state_d;
      bal_q        <= bal_d;
      idle_q       <= idle_d;
      pin_err      <= pin_err_d;
      insuff       <= insuff_d;
      timeout      <= timeout_d;
      auth_ok      <= state_d inside {StMenu, StShowBal, StAmount, StDispense};
      bal_valid    <= (state_d == StShowBal);
      balance_out  <= (state_d == StShowBal) ? bal_d : '0;
      dispense_req <= (state_d == StDispense);
      dispense_amt <= damt_d;
    end
  end

  assign state = state_q;

endmodule
